// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - stall/flush sequencer for the 5-stage pipeline
//
// Sits beside decode. It stalls on load-use hazards against the EX-stage load,
// holds the pipeline while a data-memory access is outstanding, and turns a
// decode-resolved redirect into a PC load plus an IF/ID flush. It also keeps
// saturating stall and flush performance counters.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   id_rs1, id_rs2                decode source registers
//   id_use_rs1, id_use_rs2        decode instruction reads rs1 / rs2
//   ex_mem_read, ex_reg_en        EX-stage instruction is a load / writes the RF
//   ex_dest_reg                   EX-stage destination register
//   redirect_valid/target         taken branch / JAL / JALR from decode, new PC
//   dmem_req, dmem_ready          MEM access in flight / completes this cycle
//   pc_stall, if_id_stall         hold PC / hold IF/ID
//   if_id_flush                   zero IF/ID
//   id_ex_bubble, mem_wb_bubble   load NOP into ID/EX / MEM/WB
//   ex_mem_stall                  hold EX/MEM
//   pc_load, pc_target            load redirect target into PC (target 0 otherwise)
//   seq_state                     00 RUN, 01 LU_STALL, 10 MEM_WAIT
//   mem_timeout_err               sticky memory timeout flag
//   stall_cnt, flush_cnt          saturating stall-cycle / redirect counters

module pipeline_hazard_sequencer #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5,
    parameter int LU_CYCLES    = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [RegAddrWidth-1:0] id_rs1,
    input  logic [RegAddrWidth-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic                    ex_mem_read,
    input  logic                    ex_reg_en,
    input  logic [RegAddrWidth-1:0] ex_dest_reg,
    input  logic                    redirect_valid,
    input  logic [DataWidth-1:0]    redirect_target,
    input  logic                    dmem_req,
    input  logic                    dmem_ready,
    output logic                    pc_stall,
    output logic                    if_id_stall,
    output logic                    if_id_flush,
    output logic                    id_ex_bubble,
    output logic                    ex_mem_stall,
    output logic                    mem_wb_bubble,
    output logic                    pc_load,
    output logic [DataWidth-1:0]    pc_target,
    output logic [1:0]              seq_state,
    output logic                    mem_timeout_err,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    localparam int LU_W   = 3;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    state_t            state;
    logic [LU_W-1:0]   lu_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic hazard;
    logic memwait;
    logic do_mem;      // memory-wait stall pattern this cycle
    logic do_lu;       // load-use stall pattern this cycle
    logic do_redir;    // redirect accepted this cycle
    logic release_mem; // leave MEM_WAIT this cycle
    logic timeout;     // leaving MEM_WAIT because the wait budget ran out

    assign hazard = ex_mem_read & ex_reg_en & (ex_dest_reg != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_dest_reg)) |
                     (id_use_rs2 & (id_rs2 == ex_dest_reg)));
    assign memwait = dmem_req & ~dmem_ready;

    // Priority memwait > load-use > redirect. A redirect seen alongside a
    // hazard is dropped because its operands are stale; decode re-presents it.
    always_comb begin
        do_mem      = 1'b0;
        do_lu       = 1'b0;
        do_redir    = 1'b0;
        release_mem = 1'b0;
        timeout     = 1'b0;
        if (reset) begin
            case (state)
                RUN: begin
                    if (memwait)             do_mem   = 1'b1;
                    else if (hazard)         do_lu    = 1'b1;
                    else if (redirect_valid) do_redir = 1'b1;
                end
                LU_STALL: begin
                    if (memwait) do_mem = 1'b1;
                    else         do_lu  = 1'b1;
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        release_mem = 1'b1;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        release_mem = 1'b1;
                        timeout     = 1'b1;
                    end else begin
                        do_mem = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ID/EX is held (not bubbled) during a memory wait; the branch itself
    // proceeds on a redirect, so only IF/ID is flushed.
    assign pc_stall      = do_mem | do_lu;
    assign if_id_stall   = do_mem | do_lu;
    assign ex_mem_stall  = do_mem;
    assign mem_wb_bubble = do_mem;
    assign id_ex_bubble  = do_lu;
    assign pc_load       = do_redir;
    assign if_id_flush   = do_redir;
    assign pc_target     = do_redir ? redirect_target : '0;
    assign seq_state     = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= RUN;
            lu_cnt          <= '0;
            wait_cnt        <= '0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            if (pc_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (pc_load && !(&flush_cnt))  flush_cnt <= flush_cnt + CNT_W'(1);

            case (state)
                RUN: begin
                    if (do_mem) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else if (do_lu && (LU_CYCLES > 1)) begin
                        state  <= LU_STALL;
                        lu_cnt <= LU_W'(LU_CYCLES - 1);
                    end
                end
                LU_STALL: begin
                    // lu_cnt stays frozen across a memory wait and resumes after.
                    if (do_mem) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else begin
                        lu_cnt <= lu_cnt - LU_W'(1);
                        if (lu_cnt == LU_W'(1)) state <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (release_mem) begin
                        wait_cnt <= '0;
                        if (timeout) mem_timeout_err <= 1'b1;
                        state <= (lu_cnt != '0) ? LU_STALL : RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb/tb_pipeline_hazard_sequencer.sv - scoreboard bench for pipeline_hazard_sequencer

module tb_pipeline_hazard_sequencer;

    localparam int CW = 4;

    // control bit order: pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
    //                    ex_mem_stall, mem_wb_bubble, pc_load
    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_LU   = 7'b110_1000;
    localparam logic [6:0] C_MEM  = 7'b110_0110;
    localparam logic [6:0] C_RED  = 7'b001_0001;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_dest_reg;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_en;
    logic        redirect_valid, dmem_req, dmem_ready;
    logic [31:0] redirect_target;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic        ex_mem_stall, mem_wb_bubble, pc_load, mem_timeout_err;
    logic [31:0] pc_target;
    logic [1:0]  seq_state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_sequencer #(
        .DataWidth(32), .RegAddrWidth(5), .LU_CYCLES(2), .MEM_TIMEOUT(8), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_reg_en(ex_reg_en), .ex_dest_reg(ex_dest_reg),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .pc_load(pc_load), .pc_target(pc_target),
        .seq_state(seq_state), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [6:0]  ctrl;
        logic [31:0] tgt;
        logic [1:0]  st;
        logic        err;
        int          sc;
        int          fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic int sat(input int n);
        return (n > (2**CW - 1)) ? (2**CW - 1) : n;
    endfunction

    task automatic check(input string nm, input string f,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare the
    // oldest pending expectation at the falling edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "ctrl", 32'({pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                                       ex_mem_stall, mem_wb_bubble, pc_load}), 32'(e.ctrl));
            check(e.name, "pc_target", pc_target, e.tgt);
            check(e.name, "seq_state", 32'(seq_state), 32'(e.st));
            check(e.name, "timeout_err", 32'(mem_timeout_err), 32'(e.err));
            check(e.name, "stall_cnt", 32'(stall_cnt), 32'(sat(e.sc)));
            check(e.name, "flush_cnt", 32'(flush_cnt), 32'(sat(e.fc)));
        end
    end

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_reg_en = 0; ex_dest_reg = '0;
        redirect_valid = 0; redirect_target = '0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic load_use(input logic [4:0] dest, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic reg_en);
        ex_mem_read = 1; ex_reg_en = reg_en; ex_dest_reg = dest;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    // Push this cycle's expectation, then advance to just after the next edge.
    task automatic cyc(input string nm, input logic [6:0] ctrl, input logic [31:0] tgt,
                       input logic [1:0] st, input logic err, input int sc, input int fc);
        exp_t e;
        e.name = nm; e.ctrl = ctrl; e.tgt = tgt; e.st = st;
        e.err = err; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 0;
        idle();
        @(posedge clock);
        #1;

        // reset with random inputs: all outputs quiet
        for (int i = 0; i < 3; i++) begin
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); ex_dest_reg = 5'($urandom);
            {id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_en} = 4'($urandom);
            {redirect_valid, dmem_req, dmem_ready} = 3'($urandom);
            redirect_target = $urandom;
            cyc("reset", C_NONE, 0, 2'b00, 0, 0, 0);
        end
        reset = 1;
        idle();
        cyc("idle", C_NONE, 0, 2'b00, 0, 0, 0);

        // load-use on rs2, two bubbles
        load_use(5, 0, 0, 5, 1, 1);
        cyc("lu_rs2_a", C_LU, 0, 2'b00, 0, 0, 0);
        idle();
        cyc("lu_rs2_b", C_LU, 0, 2'b01, 0, 1, 0);
        cyc("lu_done", C_NONE, 0, 2'b00, 0, 2, 0);

        // hazard wins over redirect; redirect accepted once back in RUN
        load_use(7, 7, 1, 0, 0, 1);
        redirect_valid = 1; redirect_target = 32'h40;
        cyc("lu_vs_redir", C_LU, 0, 2'b00, 0, 2, 0);
        idle();
        redirect_valid = 1; redirect_target = 32'h80;
        cyc("lu_stall_redir", C_LU, 0, 2'b01, 0, 3, 0);
        cyc("redir_80", C_RED, 32'h80, 2'b00, 0, 4, 0);
        idle();
        cyc("post_redir", C_NONE, 0, 2'b00, 0, 4, 1);

        // non-hazards: x0 destination, no RF write, register not read
        load_use(0, 0, 1, 0, 0, 1);
        redirect_valid = 1; redirect_target = 32'h100;
        cyc("x0_dest", C_RED, 32'h100, 2'b00, 0, 4, 1);
        idle();
        load_use(9, 9, 1, 0, 0, 0);
        cyc("no_reg_en", C_NONE, 0, 2'b00, 0, 4, 2);
        idle();
        load_use(9, 9, 0, 3, 1, 1);
        cyc("rs1_unused", C_NONE, 0, 2'b00, 0, 4, 2);

        // memory wait: ready low 4 cycles, then high
        idle();
        dmem_req = 1;
        cyc("mw_enter", C_MEM, 0, 2'b00, 0, 4, 2);
        cyc("mw_2", C_MEM, 0, 2'b10, 0, 5, 2);
        redirect_valid = 1; redirect_target = 32'h200;
        cyc("mw_redir_ign", C_MEM, 0, 2'b10, 0, 6, 2);
        redirect_valid = 0;
        cyc("mw_4", C_MEM, 0, 2'b10, 0, 7, 2);
        dmem_ready = 1;
        cyc("mw_release", C_NONE, 0, 2'b10, 0, 8, 2);
        idle();
        cyc("mw_done", C_NONE, 0, 2'b00, 0, 8, 2);

        // timeout after 8 wait cycles; stall_cnt saturates along the way
        dmem_req = 1;
        cyc("to_enter", C_MEM, 0, 2'b00, 0, 8, 2);
        for (int i = 1; i <= 7; i++) cyc("to_wait", C_MEM, 0, 2'b10, 0, 8 + i, 2);
        cyc("to_fire", C_NONE, 0, 2'b10, 0, 16, 2);
        idle();
        cyc("to_sticky_a", C_NONE, 0, 2'b00, 1, 16, 2);
        cyc("to_sticky_b", C_NONE, 0, 2'b00, 1, 16, 2);

        // memwait interrupting LU_STALL; lu_cnt resumes afterwards
        load_use(3, 0, 0, 3, 1, 1);
        cyc("lum_hazard", C_LU, 0, 2'b00, 1, 16, 2);
        idle();
        dmem_req = 1;
        cyc("lum_memwait", C_MEM, 0, 2'b01, 1, 17, 2);
        dmem_ready = 1;
        cyc("lum_release", C_NONE, 0, 2'b10, 1, 18, 2);
        idle();
        cyc("lum_resume", C_LU, 0, 2'b01, 1, 18, 2);
        cyc("lum_run", C_NONE, 0, 2'b00, 1, 19, 2);

        // reset in the middle of a memory wait
        dmem_req = 1;
        cyc("rst_mw_a", C_MEM, 0, 2'b00, 1, 19, 2);
        cyc("rst_mw_b", C_MEM, 0, 2'b10, 1, 20, 2);
        reset = 0;
        cyc("rst_mw_forced", C_NONE, 0, 2'b10, 1, 21, 2);
        reset = 1;
        idle();
        cyc("rst_mw_after", C_NONE, 0, 2'b00, 0, 0, 0);

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
